// File: rtl/writeback_register_if.sv
// Bundle of the M->W pipeline register signals: memory-stage results and W control
// in, writeback/status/performance outputs back to the core.
interface writeback_register_if #(
  parameter int CNT_W = 32
);
  logic [3:0]       M_stat;
  logic [3:0]       M_icode;
  logic [3:0]       M_dstE;
  logic [3:0]       M_dstM;
  logic [63:0]      M_valE;
  logic [63:0]      m_valM;
  logic             W_stall;
  logic             W_bubble;
  logic [3:0]       W_stat;
  logic [3:0]       W_icode;
  logic [3:0]       W_dstE;
  logic [3:0]       W_dstM;
  logic [63:0]      W_valE;
  logic [63:0]      W_valM;
  logic             halted;
  logic             fault;
  logic [CNT_W-1:0] retired;
  logic [CNT_W-1:0] cycles;
  logic [1:0]       state_dbg;

  // No handshake: the register samples its inputs on every clock edge; W_stall and
  // W_bubble are level controls evaluated at that edge.
  modport master (
    output M_stat, M_icode, M_dstE, M_dstM, M_valE, m_valM, W_stall, W_bubble,
    input  W_stat, W_icode, W_dstE, W_dstM, W_valE, W_valM, halted, fault,
           retired, cycles, state_dbg
  );

  modport slave (
    input  M_stat, M_icode, M_dstE, M_dstM, M_valE, m_valM, W_stall, W_bubble,
    output W_stat, W_icode, W_dstE, W_dstM, W_valE, W_valM, halted, fault,
           retired, cycles, state_dbg
  );
endinterface

// File: rtl/writeback_register.sv
// Y86 M->W pipeline register with stall/bubble control, run/halt/fault status FSM and
// retire/cycle counters. Define WB_TRACE_EN for a simulation trace of retires and stops.
module writeback_register #(
  parameter int         CNT_W = 32,
  parameter logic [3:0] RNONE = 4'hF
) (
  input logic              clk,
  input logic              rst,
  writeback_register_if.slave wb
);
  localparam logic [3:0] STAT_AOK  = 4'd1;
  localparam logic [3:0] STAT_HLT  = 4'd2;
  localparam logic [3:0] STAT_ADR  = 4'd3;
  localparam logic [3:0] STAT_INS  = 4'd4;
  localparam logic [3:0] ICODE_NOP = 4'h1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    FAULT  = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] stat_n;
  logic [3:0] dste_n;
  logic [3:0] dstm_n;
  logic       load;
  logic       retire;

  // Unknown status codes are folded into INS so they stop the core like a bad opcode.
  always_comb begin
    stat_n = STAT_INS;
    if (wb.M_stat == STAT_AOK || wb.M_stat == STAT_HLT || wb.M_stat == STAT_ADR)
      stat_n = wb.M_stat;
    dste_n = (stat_n == STAT_AOK) ? wb.M_dstE : RNONE;
    dstm_n = (stat_n == STAT_AOK) ? wb.M_dstM : RNONE;
    load   = (state == RUN) && !wb.W_bubble && !wb.W_stall;
    retire = load && (((stat_n == STAT_AOK) && (wb.M_icode != ICODE_NOP)) ||
                      (stat_n == STAT_HLT));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      wb.W_stat  <= STAT_AOK;
      wb.W_icode <= ICODE_NOP;
      wb.W_dstE  <= RNONE;
      wb.W_dstM  <= RNONE;
      wb.W_valE  <= '0;
      wb.W_valM  <= '0;
      wb.halted  <= 1'b0;
      wb.fault   <= 1'b0;
      wb.retired <= '0;
      wb.cycles  <= '0;
    end else if (state == RUN) begin
      wb.cycles <= wb.cycles + CNT_ONE;
      if (wb.W_bubble) begin
        wb.W_stat  <= STAT_AOK;
        wb.W_icode <= ICODE_NOP;
        wb.W_dstE  <= RNONE;
        wb.W_dstM  <= RNONE;
        wb.W_valE  <= '0;
        wb.W_valM  <= '0;
      end else if (load) begin
        wb.W_stat  <= stat_n;
        wb.W_icode <= wb.M_icode;
        wb.W_dstE  <= dste_n;
        wb.W_dstM  <= dstm_n;
        wb.W_valE  <= wb.M_valE;
        wb.W_valM  <= wb.m_valM;
        if (retire)
          wb.retired <= wb.retired + CNT_ONE;
        if (stat_n == STAT_HLT) begin
          state     <= HALTED;
          wb.halted <= 1'b1;
        end else if (stat_n != STAT_AOK) begin
          state    <= FAULT;
          wb.fault <= 1'b1;
        end
      end
    end
  end

  assign wb.state_dbg = state;

`ifdef WB_TRACE_EN
  always @(posedge clk) begin
    if (!rst && retire)
      $display("wb retire cycles=%0h icode=%h E=%h:%h M=%h:%h",
               wb.cycles, wb.M_icode, dste_n, wb.M_valE, dstm_n, wb.m_valM);
    if (!rst && load && stat_n != STAT_AOK)
      $display("wb enter %s stat=%h", (stat_n == STAT_HLT) ? "HALTED" : "FAULT", stat_n);
  end
`else
  // Trace disabled: no simulation output.
`endif
endmodule

// File: tb/tb_writeback_register.sv
// Scoreboard bench for writeback_register: stimulus pushes the reference model's
// expected post-edge outputs, a monitor pops and compares one entry per clock.
module tb_writeback_register;
  localparam int CNT_W = 4;
  localparam int EW    = 146 + 2 * CNT_W;
  localparam int CMOD  = 1 << CNT_W;

  logic clk;
  logic rst;
  writeback_register_if #(.CNT_W(CNT_W)) wb();

  writeback_register #(.CNT_W(CNT_W), .RNONE(4'hF)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (wb)
  );

  // clock/reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // reference model state (architectural view)
  int          m_mode;   // 0 running, 1 halted, 2 faulted
  int          m_ret;
  int          m_cyc;
  logic [3:0]  w_stat, w_icode, w_dste, w_dstm;
  logic [63:0] w_vale, w_valm;

  logic [EW-1:0] exp_q[$];
  int compared   = 0;
  int mismatched = 0;
  int cyc_no     = 0;

  function automatic logic [EW-1:0] pack(
      input logic [3:0] st, ic, de, dm, input logic [63:0] ve, vm,
      input logic h, f, input logic [CNT_W-1:0] r, c);
    return {st, ic, de, dm, ve, vm, h, f, r, c};
  endfunction

  function automatic logic [EW-1:0] model_vec();
    return pack(w_stat, w_icode, w_dste, w_dstm, w_vale, w_valm,
                m_mode == 1, m_mode == 2, CNT_W'(m_ret), CNT_W'(m_cyc));
  endfunction

  function automatic logic [EW-1:0] dut_vec();
    return pack(wb.W_stat, wb.W_icode, wb.W_dstE, wb.W_dstM, wb.W_valE, wb.W_valM,
                wb.halted, wb.fault, wb.retired, wb.cycles);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_ret = 0; m_cyc = 0;
    w_stat = 4'd1; w_icode = 4'd1; w_dste = 4'hF; w_dstm = 4'hF;
    w_vale = '0; w_valm = '0;
  endtask

  // driver: called at a negedge, applies one cycle of inputs, returns at next negedge
  task automatic drive(input logic [3:0] st, ic, de, dm,
                       input logic [63:0] ve, vm, input logic stl, bub);
    int eff;
    wb.M_stat = st; wb.M_icode = ic; wb.M_dstE = de; wb.M_dstM = dm;
    wb.M_valE = ve; wb.m_valM = vm; wb.W_stall = stl; wb.W_bubble = bub;
    if (m_mode == 0) begin
      m_cyc = (m_cyc + 1) % CMOD;
      if (bub) begin
        w_stat = 4'd1; w_icode = 4'd1; w_dste = 4'hF; w_dstm = 4'hF;
        w_vale = '0; w_valm = '0;
      end else if (!stl) begin
        eff = (st >= 1 && st <= 3) ? int'(st) : 4;
        w_stat = 4'(eff); w_icode = ic; w_vale = ve; w_valm = vm;
        w_dste = (eff == 1) ? de : 4'hF;
        w_dstm = (eff == 1) ? dm : 4'hF;
        if ((eff == 1 && ic != 4'd1) || eff == 2) m_ret = (m_ret + 1) % CMOD;
        if (eff == 2) m_mode = 1;
        else if (eff != 1) m_mode = 2;
      end
    end
    exp_q.push_back(model_vec());
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(4'd1, 4'd1, 4'hF, 4'hF, 64'd0, 64'd0, 1'b0, 1'b0);
  endtask

  // asynchronous reset raised mid-cycle; checked before any clock edge can occur
  task automatic do_reset();
    #2 rst = 1'b1;
    model_reset();
    #1;
    compared++;
    if (dut_vec() !== model_vec()) begin
      mismatched++;
      $display("FAIL reset_async: got %h required %h", dut_vec(), model_vec());
    end
    if (wb.state_dbg !== 2'd0) begin
      mismatched++;
      $display("FAIL reset_state: got %0d required 0", wb.state_dbg);
    end
    compared++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // monitor / scoreboard
  always begin
    @(posedge clk);
    #1;
    cyc_no++;
    if (exp_q.size() > 0) begin
      logic [EW-1:0] e;
      e = exp_q.pop_front();
      compared++;
      if (dut_vec() !== e) begin
        mismatched++;
        $display("FAIL w_outputs cycle %0d: got %h required %h", cyc_no, dut_vec(), e);
      end
    end
  end

  initial begin
    int r;
    logic [3:0] st;
    rst = 1'b1;
    wb.M_stat = 4'd1; wb.M_icode = 4'd1; wb.M_dstE = 4'hF; wb.M_dstM = 4'hF;
    wb.M_valE = '0; wb.m_valM = '0; wb.W_stall = 1'b0; wb.W_bubble = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    idle(3);
    drive(4'd1, 4'd6, 4'd2, 4'hF, 64'h10, 64'h0, 1'b0, 1'b0);             // OPq
    drive(4'd1, 4'hB, 4'd4, 4'd3, 64'h100, 64'h55, 1'b0, 1'b0);           // popq
    drive(4'd1, 4'd6, 4'd7, 4'hF, 64'h77, 64'h0, 1'b1, 1'b0);             // stalled
    drive(4'd1, 4'd6, 4'd7, 4'hF, 64'h77, 64'h0, 1'b0, 1'b0);             // loads
    drive(4'd1, 4'd6, 4'd8, 4'hF, 64'h88, 64'h0, 1'b1, 1'b1);             // bubble wins
    drive(4'd1, 4'hB, 4'd4, 4'd4, 64'h200, 64'h300, 1'b0, 1'b0);          // popq %rsp
    drive(4'd3, 4'd5, 4'hF, 4'd5, 64'h1000, 64'h0, 1'b0, 1'b0);           // mrmovq ADR
    drive(4'd1, 4'd6, 4'd1, 4'hF, 64'h9, 64'h0, 1'b0, 1'b0);              // ignored
    drive(4'd1, 4'd6, 4'd1, 4'hF, 64'h9, 64'h0, 1'b0, 1'b1);              // ignored
    do_reset();

    idle(17);                                                             // cycles wraps to 1
    drive(4'd2, 4'd0, 4'hF, 4'hF, 64'h0, 64'h0, 1'b0, 1'b0);              // halt
    drive(4'd1, 4'd6, 4'd2, 4'hF, 64'h5, 64'h0, 1'b0, 1'b0);              // frozen
    do_reset();
    drive(4'd9, 4'd6, 4'd2, 4'd3, 64'h5, 64'h6, 1'b0, 1'b0);              // unknown -> INS
    drive(4'd1, 4'd6, 4'd2, 4'hF, 64'h5, 64'h0, 1'b0, 1'b0);
    do_reset();

    for (int i = 0; i < 400; i++) begin
      if (m_mode != 0 && $urandom_range(0, 2) == 0) do_reset();
      r = $urandom_range(0, 99);
      if (r < 90)      st = 4'd1;
      else if (r < 93) st = 4'd2;
      else if (r < 96) st = 4'd3;
      else if (r < 98) st = 4'd4;
      else             st = 4'($urandom_range(0, 15));
      drive(st, 4'($urandom_range(0, 11)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), {$urandom, $urandom}, {$urandom, $urandom},
            $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0);
    end

    @(negedge clk);
    @(negedge clk);
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL queue_drain: got %0d left required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/writeback_register.md
Name: writeback_register

Overview:
- M→W pipeline register and writeback driver for the pipelined Y86 core.
- Latches memory-stage results and presents W_icode/W_dstE/W_valE/W_dstM/W_valM/W_stat to the decode/register-file stage. These are the write-port and forwarding-source signals.
- Applies stall/bubble control and tracks processor status (run/halt/fault) in a small FSM.
- Counts retired instructions and run cycles for performance reporting.

Parameters:
- CNT_W, 32, width of the retire and cycle counters.
- RNONE, 4'hF, register ID meaning "no register / no write".

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- M_stat  input  4  memory-stage status: 1=AOK, 2=HLT, 3=ADR, 4=INS.
- M_icode  input  4  memory-stage icode.
- M_dstE  input  4  E destination register ID.
- M_dstM  input  4  M destination register ID.
- M_valE  input  64  ALU result (signed).
- m_valM  input  64  memory read data (signed).
- W_stall  input  1  hold W register contents.
- W_bubble  input  1  inject bubble into W.
- W_stat  output  4  latched status.
- W_icode  output  4  latched icode.
- W_dstE  output  4  E write port register ID; RNONE means no write.
- W_dstM  output  4  M write port register ID; RNONE means no write.
- W_valE  output  64  E write data.
- W_valM  output  64  M write data.
- halted  output  1  FSM in HALTED.
- fault  output  1  FSM in FAULT.
- retired  output  CNT_W  retired-instruction count.
- cycles  output  CNT_W  cycles spent in RUN.

Behaviour:
- Reset (asynchronous, active-high): clk; rst asynchronous active-high.
  - Bubble values: W_stat=1, W_icode=4'h1 (nop), W_dstE=W_dstM=RNONE, W_valE=W_valM=0.
  - FSM=RUN; retired=0; cycles=0; halted=fault=0.
  - Reset asserted mid-operation discards the latched instruction immediately, with no clock edge needed.
- FSM states: RUN, HALTED, FAULT.
  - RUN→HALTED when the register loads M_stat=2.
  - RUN→FAULT when the register loads M_stat=3 or 4.
  - Other M_stat values in RUN are treated as 4 (INS).
  - HALTED and FAULT are terminal until reset.
- Register update at posedge, in priority order:
  - 1. FSM≠RUN: hold all fields; W_stall/W_bubble ignored.
  - 2. W_bubble=1: load bubble values. Bubble wins over a simultaneous W_stall.
  - 3. W_stall=1: hold.
  - 4. Otherwise load the M_* / m_valM fields.
- Load with M_stat≠AOK: W_dstE and W_dstM are forced to RNONE, so a faulting or halting instruction never writes the register file. W_stat, W_icode, W_valE and W_valM still load.
- Latency: exactly 1 cycle, M inputs to W outputs. Outputs are purely registered, with no combinational input→output path.
- When W_dstE=W_dstM≠RNONE (popq %rsp case), both ports present their data. The register file gives M priority. This block does not alter the IDs.
- retired: increments on a load (case 4) with M_stat=AOK and M_icode≠1. Bubbles and nops do not count. A halt instruction counts once, on the load of M_stat=2.
- cycles: increments every clock edge while FSM=RUN, including the edge that leaves RUN.
- Counter overflow: both counters wrap modulo 2^CNT_W.
- halted = (FSM==HALTED); fault = (FSM==FAULT). Both are registered.

Optional Feature:
- Macro: WB_TRACE_EN.
- Defined: on every retire increment, emit one $display line with the cycles value, W_icode, W_dstE:W_valE and W_dstM:W_valM (hex). On entering HALTED or FAULT, emit one line naming the state and W_stat.
- Undefined: no simulation output. Synthesizable logic is identical in both builds.

Test Plan:
- Reset then 3 idle cycles (M_stat=1, M_icode=1, dst=F) → W_icode=1, W_dstE=W_dstM=F, retired=0, cycles=3.
- Load OPq: M_icode=6, M_dstE=2, M_valE=0x10, M_stat=1 → next cycle W_dstE=2, W_valE=0x10, W_dstM=F, retired=1.
- Loaded popq (W_dstE=4, W_valE=0x100), then present new data with W_stall=1 → outputs unchanged and retired unchanged. Drop W_stall → new data loads. Assert W_stall and W_bubble together → bubble values loaded.
- mrmovq with M_stat=3 (ADR), M_dstM=5 → W_stat=3, W_dstM=F, fault=1, retired unchanged. Further inputs ignored and cycles frozen.
- halt with M_stat=2 → halted=1, retired +1, outputs frozen. Assert rst asynchronously mid-cycle → immediate reset values, FSM=RUN.
- Preset counter via CNT_W=4 and run 17 RUN cycles → cycles=1 (wrap).
